// File: rtl/pio_csr_bank_if.sv
// Processor bus port of the PIO CSR bank: single-cycle write/read requests,
// registered read data with valid/error response.
interface pio_csr_bank_if;
  logic        write_en;
  logic [8:0]  write_addr;
  logic [3:0]  write_strb;
  logic [31:0] data_in;
  logic        read_en;
  logic [8:0]  read_addr;
  logic [31:0] data_out;
  logic        read_valid;
  logic        resp_err;

  modport master (
    output write_en, write_addr, write_strb, data_in, read_en, read_addr,
    input  data_out, read_valid, resp_err
  );

  modport slave (
    input  write_en, write_addr, write_strb, data_in, read_en, read_addr,
    output data_out, read_valid, resp_err
  );
endinterface

// File: rtl/pio_csr_bank.sv
// PIO control/status register bank: software-visible configuration, sticky W1C
// debug/IRQ flags, self-clearing command pulses and the two IRQ request lines.
module pio_csr_bank #(
  parameter int unsigned NUM_SM     = 4,
  parameter int unsigned IMEM_SIZE  = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pio_csr_bank_if.slave        bus,
  output logic [NUM_SM-1:0]    sm_en,
  output logic [NUM_SM-1:0]    sm_restart,
  output logic [NUM_SM-1:0]    clkdiv_restart,
  input  logic [4*NUM_SM-1:0]  fifo_stat,
  input  logic [8*NUM_SM-1:0]  fifo_level,
  input  logic [4*NUM_SM-1:0]  fdebug_set,
  input  logic [7:0]           irq_set,
  input  logic [7:0]           irq_clr,
  output logic [31:0]          sync_bypass,
  input  logic [31:0]          dbg_padout,
  input  logic [31:0]          dbg_padoe,
  output logic [24*NUM_SM-1:0] sm_clkdiv,
  output logic [32*NUM_SM-1:0] sm_execctrl,
  output logic [16*NUM_SM-1:0] sm_shiftctrl,
  output logic [32*NUM_SM-1:0] sm_pinctrl,
  input  logic [5*NUM_SM-1:0]  sm_addr,
  input  logic [16*NUM_SM-1:0] sm_instr_cur,
  output logic [16*NUM_SM-1:0] sm_instr,
  output logic [NUM_SM-1:0]    sm_instr_valid,
  input  logic [3*NUM_SM-1:0]  intr_src,
  output logic [1:0]           irq_out
);

  localparam logic [8:0] AddrCtrl       = 9'h000;
  localparam logic [8:0] AddrFstat      = 9'h004;
  localparam logic [8:0] AddrFdebug     = 9'h008;
  localparam logic [8:0] AddrFlevel     = 9'h00C;
  localparam logic [8:0] AddrIrq        = 9'h030;
  localparam logic [8:0] AddrSyncBypass = 9'h038;
  localparam logic [8:0] AddrPadout     = 9'h03C;
  localparam logic [8:0] AddrPadoe      = 9'h040;
  localparam logic [8:0] AddrCfgInfo    = 9'h044;
  localparam logic [8:0] AddrIntr       = 9'h190;
  localparam logic [8:0] AddrInte0      = 9'h194;
  localparam logic [8:0] AddrIntf0      = 9'h198;
  localparam logic [8:0] AddrInts0      = 9'h19C;
  localparam logic [8:0] AddrInte1      = 9'h1A0;
  localparam logic [8:0] AddrIntf1      = 9'h1A4;
  localparam logic [8:0] AddrInts1      = 9'h1A8;

  localparam int unsigned SmBase    = 200;
  localparam int unsigned SmStride  = 24;
  localparam int unsigned OffClkdiv = 0;
  localparam int unsigned OffExec   = 4;
  localparam int unsigned OffShift  = 8;
  localparam int unsigned OffAddr   = 12;
  localparam int unsigned OffInstr  = 16;
  localparam int unsigned OffPin    = 20;

  localparam logic [7:0]  SmMask     = 8'((1 << NUM_SM) - 1);
  localparam logic [23:0] IntMask    = {3{SmMask}};
  // EXECCTRL bit 31 and bits 6:5 are status-only and never stored
  localparam logic [31:0] ExecWrMask = 32'h7FFF_FF9F;
  localparam int unsigned FlvSms     = (NUM_SM < 4) ? NUM_SM : 4;
  localparam logic [31:0] CfgInfo    =
      {10'b0, 6'(IMEM_SIZE), 4'b0, 4'(NUM_SM), 2'b0, 6'(FIFO_DEPTH)};

  function automatic logic [8:0] sm_reg(input int unsigned n, input int unsigned off);
    return 9'(SmBase + SmStride * n + off);
  endfunction

  // State
  logic [NUM_SM-1:0]        sm_en_q, sm_en_d;
  logic [NUM_SM-1:0]        sm_restart_q, sm_restart_d;
  logic [NUM_SM-1:0]        clkdiv_restart_q, clkdiv_restart_d;
  logic [31:0]              fdebug_q, fdebug_d;
  logic [7:0]               irq_q, irq_d;
  logic [31:0]              sync_bypass_q, sync_bypass_d;
  logic [23:0]              inte0_q, inte0_d, intf0_q, intf0_d;
  logic [23:0]              inte1_q, inte1_d, intf1_q, intf1_d;
  logic [NUM_SM-1:0][23:0]  clkdiv_q, clkdiv_d;
  logic [NUM_SM-1:0][31:0]  execctrl_q, execctrl_d;
  logic [NUM_SM-1:0][15:0]  shiftctrl_q, shiftctrl_d;
  logic [NUM_SM-1:0][31:0]  pinctrl_q, pinctrl_d;
  logic [NUM_SM-1:0][15:0]  sm_instr_q, sm_instr_d;
  logic [NUM_SM-1:0]        sm_instr_valid_q, sm_instr_valid_d;
  logic [1:0]               irq_out_q, irq_out_d;
  logic [31:0]              data_out_q, data_out_d;
  logic                     read_valid_q;
  logic                     resp_err_q, resp_err_d;

  // Byte-padded views of the per-SM input buses
  logic [31:0] fstat_word, fdebug_set_word, flevel_word;
  logic [23:0] intr_word, ints0, ints1;

  logic [31:0] wmask, wdata, wr_tmp;
  logic        wr_hit;
  logic [31:0] rd_data;
  logic        rd_hit;
  logic [31:0] fdebug_sw_clr;
  logic [7:0]  irq_sw_clr;

  // Spread NUM_SM-wide fields onto byte lanes
  always_comb begin
    fstat_word      = '0;
    fdebug_set_word = '0;
    intr_word       = '0;
    flevel_word     = '0;
    for (int k = 0; k < 4; k++) begin
      fstat_word[8*k +: NUM_SM]      = fifo_stat[NUM_SM*k +: NUM_SM];
      fdebug_set_word[8*k +: NUM_SM] = fdebug_set[NUM_SM*k +: NUM_SM];
    end
    for (int k = 0; k < 3; k++) begin
      intr_word[8*k +: NUM_SM] = intr_src[NUM_SM*k +: NUM_SM];
    end
    flevel_word[8*FlvSms-1:0] = fifo_level[8*FlvSms-1:0];
  end

  assign ints0 = (intr_word | intf0_q) & inte0_q;
  assign ints1 = (intr_word | intf1_q) & inte1_q;

  // Read decode from pre-write state, so a same-cycle write is not visible
  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    case (bus.read_addr)
      AddrCtrl:       begin rd_hit = 1'b1; rd_data[NUM_SM-1:0] = sm_en_q; end
      AddrFstat:      begin rd_hit = 1'b1; rd_data = fstat_word;          end
      AddrFdebug:     begin rd_hit = 1'b1; rd_data = fdebug_q;            end
      AddrFlevel:     begin rd_hit = 1'b1; rd_data = flevel_word;         end
      AddrIrq:        begin rd_hit = 1'b1; rd_data = {24'b0, irq_q};      end
      AddrSyncBypass: begin rd_hit = 1'b1; rd_data = sync_bypass_q;       end
      AddrPadout:     begin rd_hit = 1'b1; rd_data = dbg_padout;          end
      AddrPadoe:      begin rd_hit = 1'b1; rd_data = dbg_padoe;           end
      AddrCfgInfo:    begin rd_hit = 1'b1; rd_data = CfgInfo;             end
      AddrIntr:       begin rd_hit = 1'b1; rd_data = {8'b0, intr_word};   end
      AddrInte0:      begin rd_hit = 1'b1; rd_data = {8'b0, inte0_q};     end
      AddrIntf0:      begin rd_hit = 1'b1; rd_data = {8'b0, intf0_q};     end
      AddrInts0:      begin rd_hit = 1'b1; rd_data = {8'b0, ints0};       end
      AddrInte1:      begin rd_hit = 1'b1; rd_data = {8'b0, inte1_q};     end
      AddrIntf1:      begin rd_hit = 1'b1; rd_data = {8'b0, intf1_q};     end
      AddrInts1:      begin rd_hit = 1'b1; rd_data = {8'b0, ints1};       end
      default:        ;
    endcase
    for (int unsigned n = 0; n < NUM_SM; n++) begin
      if (bus.read_addr == sm_reg(n, OffClkdiv)) begin
        rd_hit  = 1'b1;
        rd_data = {clkdiv_q[n], 8'b0};
      end
      if (bus.read_addr == sm_reg(n, OffExec)) begin
        rd_hit  = 1'b1;
        rd_data = execctrl_q[n];
      end
      if (bus.read_addr == sm_reg(n, OffShift)) begin
        rd_hit  = 1'b1;
        rd_data = {shiftctrl_q[n], 16'b0};
      end
      if (bus.read_addr == sm_reg(n, OffAddr)) begin
        rd_hit  = 1'b1;
        rd_data = {27'b0, sm_addr[5*n +: 5]};
      end
      if (bus.read_addr == sm_reg(n, OffInstr)) begin
        rd_hit  = 1'b1;
        rd_data = {16'b0, sm_instr_cur[16*n +: 16]};
      end
      if (bus.read_addr == sm_reg(n, OffPin)) begin
        rd_hit  = 1'b1;
        rd_data = pinctrl_q[n];
      end
    end
  end

  // Write decode and next-state for every register
  always_comb begin
    wmask = {{8{bus.write_strb[3]}}, {8{bus.write_strb[2]}},
             {8{bus.write_strb[1]}}, {8{bus.write_strb[0]}}};
    wdata = bus.data_in & wmask;
    wr_tmp           = '0;
    wr_hit           = 1'b0;
    sm_en_d          = sm_en_q;
    sm_restart_d     = '0;
    clkdiv_restart_d = '0;
    sync_bypass_d    = sync_bypass_q;
    inte0_d          = inte0_q;
    intf0_d          = intf0_q;
    inte1_d          = inte1_q;
    intf1_d          = intf1_q;
    fdebug_sw_clr    = '0;
    irq_sw_clr       = '0;
    clkdiv_d         = clkdiv_q;
    execctrl_d       = execctrl_q;
    shiftctrl_d      = shiftctrl_q;
    pinctrl_d        = pinctrl_q;
    sm_instr_d       = sm_instr_q;
    sm_instr_valid_d = '0;

    if (bus.write_en) begin
      case (bus.write_addr)
        AddrCtrl: begin
          wr_hit = 1'b1;
          wr_tmp[NUM_SM-1:0] = sm_en_q;
          wr_tmp = (wr_tmp & ~wmask) | wdata;
          sm_en_d          = wr_tmp[NUM_SM-1:0];
          sm_restart_d     = wdata[8 +: NUM_SM];
          clkdiv_restart_d = wdata[16 +: NUM_SM];
        end
        AddrFdebug: begin wr_hit = 1'b1; fdebug_sw_clr = wdata;    end
        AddrIrq:    begin wr_hit = 1'b1; irq_sw_clr    = wdata[7:0]; end
        AddrSyncBypass: begin
          wr_hit = 1'b1;
          sync_bypass_d = (sync_bypass_q & ~wmask) | wdata;
        end
        AddrInte0: begin
          wr_hit = 1'b1;
          wr_tmp = ({8'b0, inte0_q} & ~wmask) | wdata;
          inte0_d = wr_tmp[23:0] & IntMask;
        end
        AddrIntf0: begin
          wr_hit = 1'b1;
          wr_tmp = ({8'b0, intf0_q} & ~wmask) | wdata;
          intf0_d = wr_tmp[23:0] & IntMask;
        end
        AddrInte1: begin
          wr_hit = 1'b1;
          wr_tmp = ({8'b0, inte1_q} & ~wmask) | wdata;
          inte1_d = wr_tmp[23:0] & IntMask;
        end
        AddrIntf1: begin
          wr_hit = 1'b1;
          wr_tmp = ({8'b0, intf1_q} & ~wmask) | wdata;
          intf1_d = wr_tmp[23:0] & IntMask;
        end
        // Read-only registers accept and drop the write without an error
        AddrFstat, AddrFlevel, AddrPadout, AddrPadoe, AddrCfgInfo,
        AddrIntr, AddrInts0, AddrInts1: wr_hit = 1'b1;
        default: ;
      endcase
      for (int unsigned n = 0; n < NUM_SM; n++) begin
        if (bus.write_addr == sm_reg(n, OffClkdiv)) begin
          wr_hit = 1'b1;
          wr_tmp = ({clkdiv_q[n], 8'b0} & ~wmask) | wdata;
          clkdiv_d[n] = wr_tmp[31:8];
        end
        if (bus.write_addr == sm_reg(n, OffExec)) begin
          wr_hit = 1'b1;
          execctrl_d[n] = ((execctrl_q[n] & ~wmask) | wdata) & ExecWrMask;
        end
        if (bus.write_addr == sm_reg(n, OffShift)) begin
          wr_hit = 1'b1;
          wr_tmp = ({shiftctrl_q[n], 16'b0} & ~wmask) | wdata;
          shiftctrl_d[n] = wr_tmp[31:16];
        end
        if (bus.write_addr == sm_reg(n, OffAddr)) begin
          wr_hit = 1'b1;
        end
        if (bus.write_addr == sm_reg(n, OffInstr)) begin
          wr_hit = 1'b1;
          wr_tmp = ({16'b0, sm_instr_q[n]} & ~wmask) | wdata;
          sm_instr_d[n]       = wr_tmp[15:0];
          sm_instr_valid_d[n] = |bus.write_strb[1:0];
        end
        if (bus.write_addr == sm_reg(n, OffPin)) begin
          wr_hit = 1'b1;
          pinctrl_d[n] = (pinctrl_q[n] & ~wmask) | wdata;
        end
      end
    end

    // Hardware set beats a simultaneous software clear
    fdebug_d = (fdebug_q | fdebug_set_word) & ~(fdebug_sw_clr & ~fdebug_set_word);
    irq_d    = (irq_q & ~irq_sw_clr & ~irq_clr) | irq_set;

    irq_out_d  = {|ints1, |ints0};
    data_out_d = (bus.read_en && rd_hit) ? rd_data : 32'b0;
    resp_err_d = (bus.read_en && !rd_hit) || (bus.write_en && !wr_hit);
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sm_en_q          <= '0;
      sm_restart_q     <= '0;
      clkdiv_restart_q <= '0;
      fdebug_q         <= '0;
      irq_q            <= '0;
      sync_bypass_q    <= '0;
      inte0_q          <= '0;
      intf0_q          <= '0;
      inte1_q          <= '0;
      intf1_q          <= '0;
      clkdiv_q         <= {NUM_SM{24'h000100}};
      execctrl_q       <= {NUM_SM{32'h0001_F000}};
      shiftctrl_q      <= {NUM_SM{16'h000C}};
      pinctrl_q        <= {NUM_SM{32'h1400_0000}};
      sm_instr_q       <= '0;
      sm_instr_valid_q <= '0;
      irq_out_q        <= '0;
      data_out_q       <= '0;
      read_valid_q     <= 1'b0;
      resp_err_q       <= 1'b0;
    end else begin
      sm_en_q          <= sm_en_d;
      sm_restart_q     <= sm_restart_d;
      clkdiv_restart_q <= clkdiv_restart_d;
      fdebug_q         <= fdebug_d;
      irq_q            <= irq_d;
      sync_bypass_q    <= sync_bypass_d;
      inte0_q          <= inte0_d;
      intf0_q          <= intf0_d;
      inte1_q          <= inte1_d;
      intf1_q          <= intf1_d;
      clkdiv_q         <= clkdiv_d;
      execctrl_q       <= execctrl_d;
      shiftctrl_q      <= shiftctrl_d;
      pinctrl_q        <= pinctrl_d;
      sm_instr_q       <= sm_instr_d;
      sm_instr_valid_q <= sm_instr_valid_d;
      irq_out_q        <= irq_out_d;
      data_out_q       <= data_out_d;
      read_valid_q     <= bus.read_en;
      resp_err_q       <= resp_err_d;
    end
  end

  assign sm_en          = sm_en_q;
  assign sm_restart     = sm_restart_q;
  assign clkdiv_restart = clkdiv_restart_q;
  assign sync_bypass    = sync_bypass_q;
  assign sm_clkdiv      = clkdiv_q;
  assign sm_execctrl    = execctrl_q;
  assign sm_shiftctrl   = shiftctrl_q;
  assign sm_pinctrl     = pinctrl_q;
  assign sm_instr       = sm_instr_q;
  assign sm_instr_valid = sm_instr_valid_q;
  assign irq_out        = irq_out_q;
  assign bus.data_out   = data_out_q;
  assign bus.read_valid = read_valid_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_pio_csr_bank.sv
// Directed bench for pio_csr_bank: a 4-SM instance for the main register map and
// a 2-SM instance for the missing-SM-block and INSTR checks.
module tb_pio_csr_bank;
  localparam int unsigned N1 = 4;
  localparam int unsigned N2 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pio_csr_bank_if bus ();
  pio_csr_bank_if bus2 ();

  logic [N1-1:0]    sm_en, sm_restart, clkdiv_restart, sm_instr_valid;
  logic [4*N1-1:0]  fifo_stat, fdebug_set;
  logic [8*N1-1:0]  fifo_level;
  logic [7:0]       irq_set, irq_clr;
  logic [31:0]      sync_bypass, dbg_padout, dbg_padoe;
  logic [24*N1-1:0] sm_clkdiv;
  logic [32*N1-1:0] sm_execctrl, sm_pinctrl;
  logic [16*N1-1:0] sm_shiftctrl, sm_instr_cur, sm_instr;
  logic [5*N1-1:0]  sm_addr;
  logic [3*N1-1:0]  intr_src;
  logic [1:0]       irq_out;

  logic [N2-1:0]    sm_en2, sm_restart2, clkdiv_restart2, sm_instr_valid2;
  logic [31:0]      sync_bypass2;
  logic [24*N2-1:0] sm_clkdiv2;
  logic [32*N2-1:0] sm_execctrl2, sm_pinctrl2;
  logic [16*N2-1:0] sm_shiftctrl2, sm_instr2;
  logic [1:0]       irq_out2;

  pio_csr_bank #(.NUM_SM(N1), .IMEM_SIZE(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .sm_en(sm_en), .sm_restart(sm_restart), .clkdiv_restart(clkdiv_restart),
    .fifo_stat(fifo_stat), .fifo_level(fifo_level), .fdebug_set(fdebug_set),
    .irq_set(irq_set), .irq_clr(irq_clr), .sync_bypass(sync_bypass),
    .dbg_padout(dbg_padout), .dbg_padoe(dbg_padoe), .sm_clkdiv(sm_clkdiv),
    .sm_execctrl(sm_execctrl), .sm_shiftctrl(sm_shiftctrl), .sm_pinctrl(sm_pinctrl),
    .sm_addr(sm_addr), .sm_instr_cur(sm_instr_cur), .sm_instr(sm_instr),
    .sm_instr_valid(sm_instr_valid), .intr_src(intr_src), .irq_out(irq_out)
  );

  pio_csr_bank #(.NUM_SM(N2), .IMEM_SIZE(32), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave),
    .sm_en(sm_en2), .sm_restart(sm_restart2), .clkdiv_restart(clkdiv_restart2),
    .fifo_stat('0), .fifo_level('0), .fdebug_set('0),
    .irq_set('0), .irq_clr('0), .sync_bypass(sync_bypass2),
    .dbg_padout('0), .dbg_padoe('0), .sm_clkdiv(sm_clkdiv2),
    .sm_execctrl(sm_execctrl2), .sm_shiftctrl(sm_shiftctrl2), .sm_pinctrl(sm_pinctrl2),
    .sm_addr('0), .sm_instr_cur('0), .sm_instr(sm_instr2),
    .sm_instr_valid(sm_instr_valid2), .intr_src('0), .irq_out(irq_out2)
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input logic [8:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    if (!sel) begin
      bus.write_en = 1'b1; bus.write_addr = a; bus.data_in = d; bus.write_strb = s;
    end else begin
      bus2.write_en = 1'b1; bus2.write_addr = a; bus2.data_in = d; bus2.write_strb = s;
    end
    tick();
    bus.write_en  = 1'b0;
    bus2.write_en = 1'b0;
  endtask

  task automatic rd_issue(input bit sel, input string tag, input logic [8:0] a,
                          input logic [31:0] d, input logic e);
    exp_t x;
    x.tag = tag; x.data = d; x.err = e;
    sb.push_back(x);
    if (!sel) begin
      bus.read_en = 1'b1; bus.read_addr = a;
    end else begin
      bus2.read_en = 1'b1; bus2.read_addr = a;
    end
  endtask

  // Called #1 after the edge that accepted the read
  task automatic rd_collect(input bit sel);
    exp_t        x;
    int          n;
    logic        v;
    logic [31:0] od;
    logic        oe;
    bus.read_en  = 1'b0;
    bus2.read_en = 1'b0;
    n = 0;
    v = sel ? bus2.read_valid : bus.read_valid;
    while (v !== 1'b1 && n < 4) begin
      tick();
      n++;
      v = sel ? bus2.read_valid : bus.read_valid;
    end
    od = sel ? bus2.data_out : bus.data_out;
    oe = sel ? bus2.resp_err : bus.resp_err;
    x = sb.pop_front();
    check({x.tag, "_lat"}, 32'(n), 32'd0);
    check({x.tag, "_data"}, od, x.data);
    check({x.tag, "_err"}, 32'(oe), 32'(x.err));
  endtask

  task automatic rd(input bit sel, input string tag, input logic [8:0] a,
                    input logic [31:0] d, input logic e);
    rd_issue(sel, tag, a, d, e);
    tick();
    rd_collect(sel);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.write_en = 1'b0; bus.write_addr = '0; bus.write_strb = '0; bus.data_in = '0;
    bus.read_en = 1'b0; bus.read_addr = '0;
    bus2.write_en = 1'b0; bus2.write_addr = '0; bus2.write_strb = '0; bus2.data_in = '0;
    bus2.read_en = 1'b0; bus2.read_addr = '0;
    fifo_stat = '0; fifo_level = '0; fdebug_set = '0; irq_set = '0; irq_clr = '0;
    dbg_padout = '0; dbg_padoe = '0; sm_addr = '0; sm_instr_cur = '0; intr_src = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_sm_en", 32'(sm_en), 32'h0);
    check("rst_irq_out", 32'(irq_out), 32'h0);
    check("rst_read_valid", 32'(bus.read_valid), 32'h0);
    check("rst_resp_err", 32'(bus.resp_err), 32'h0);
    check("rst_sm_restart", 32'(sm_restart), 32'h0);
    check("rst_execctrl_out", sm_execctrl[31:0], 32'h0001_F000);
    rd(0, "clkdiv0", 9'h0C8, 32'h0001_0000, 1'b0);
    rd(0, "execctrl0", 9'h0CC, 32'h0001_F000, 1'b0);
    rd(0, "shiftctrl0", 9'h0D0, 32'h000C_0000, 1'b0);
    rd(0, "pinctrl0", 9'h0DC, 32'h1400_0000, 1'b0);

    // Byte strobes
    wr(0, 9'h0DC, 32'hAABB_CCDD, 4'b0101);
    check("pinctrl_out", sm_pinctrl[31:0], 32'h14BB_00DD);
    rd(0, "pinctrl_strb", 9'h0DC, 32'h14BB_00DD, 1'b0);

    // CTRL with self-clearing pulses
    wr(0, 9'h000, 32'h0003_0205, 4'hF);
    check("ctrl_sm_en", 32'(sm_en), 32'h5);
    check("ctrl_restart", 32'(sm_restart), 32'h2);
    check("ctrl_clkdiv_restart", 32'(clkdiv_restart), 32'h3);
    tick();
    check("ctrl_restart_drop", 32'(sm_restart), 32'h0);
    check("ctrl_clkdiv_drop", 32'(clkdiv_restart), 32'h0);
    check("ctrl_sm_en_hold", 32'(sm_en), 32'h5);
    rd(0, "ctrl_rd", 9'h000, 32'h0000_0005, 1'b0);
    wr(0, 9'h000, 32'h0000_0105, 4'hF);
    check("b2b_restart_a", 32'(sm_restart), 32'h1);
    wr(0, 9'h000, 32'h0000_0805, 4'hF);
    check("b2b_restart_b", 32'(sm_restart), 32'h8);
    tick();

    // FDEBUG sticky W1C: rx_stall[1] is fdebug_set bit 1
    fdebug_set = 16'h0002;
    tick();
    fdebug_set = '0;
    rd(0, "fdebug_set", 9'h008, 32'h0000_0002, 1'b0);
    fdebug_set = 16'h0002;
    wr(0, 9'h008, 32'h0000_0002, 4'hF);
    fdebug_set = '0;
    rd(0, "fdebug_set_wins", 9'h008, 32'h0000_0002, 1'b0);
    wr(0, 9'h008, 32'h0000_0002, 4'b1110);
    rd(0, "fdebug_strb_off", 9'h008, 32'h0000_0002, 1'b0);
    wr(0, 9'h008, 32'h0000_0002, 4'hF);
    rd(0, "fdebug_clr", 9'h008, 32'h0000_0000, 1'b0);

    // IRQ flags with hardware set/clear
    irq_set = 8'h09;
    tick();
    irq_set = '0;
    rd(0, "irq_set", 9'h030, 32'h0000_0009, 1'b0);
    irq_set = 8'h08; irq_clr = 8'h08;
    tick();
    irq_clr = 8'h01; irq_set = '0;
    tick();
    irq_clr = '0;
    rd(0, "irq_hw_clr", 9'h030, 32'h0000_0008, 1'b0);
    wr(0, 9'h030, 32'h0000_0008, 4'hF);
    rd(0, "irq_w1c", 9'h030, 32'h0000_0000, 1'b0);

    // Same-cycle read and write return the old value
    rd_issue(0, "sync_rw_same", 9'h038, 32'h0000_0000, 1'b0);
    bus.write_en = 1'b1; bus.write_addr = 9'h038; bus.data_in = 32'hCAFE_F00D;
    bus.write_strb = 4'hF;
    tick();
    bus.write_en = 1'b0;
    rd_collect(0);
    check("sync_bypass_out", sync_bypass, 32'hCAFE_F00D);
    rd(0, "sync_rd", 9'h038, 32'hCAFE_F00D, 1'b0);

    // Read-only views
    dbg_padout = 32'h1234_5678;
    fifo_stat  = 16'hA5C3;
    fifo_level = 32'h8765_4321;
    sm_instr_cur[31:16] = 16'hBEEF;
    rd(0, "padout", 9'h03C, 32'h1234_5678, 1'b0);
    rd(0, "cfginfo", 9'h044, 32'h0020_0404, 1'b0);
    rd(0, "fstat", 9'h004, 32'h0A05_0C03, 1'b0);
    rd(0, "flevel", 9'h00C, 32'h8765_4321, 1'b0);
    rd(0, "instr_cur1", 9'h0F0, 32'h0000_BEEF, 1'b0);
    wr(0, 9'h004, 32'hFFFF_FFFF, 4'hF);
    check("ro_write_err", 32'(bus.resp_err), 32'h0);

    // Unmapped accesses
    rd(0, "sm4_unmapped", 9'h128, 32'h0, 1'b1);
    rd(0, "hole_unmapped", 9'h020, 32'h0, 1'b1);
    wr(0, 9'h020, 32'hFFFF_FFFF, 4'hF);
    check("wr_unmapped_err", 32'(bus.resp_err), 32'h1);
    check("wr_unmapped_novalid", 32'(bus.read_valid), 32'h0);

    // Interrupt path
    intr_src = 12'h001;
    wr(0, 9'h194, 32'h0000_0001, 4'hF);
    check("irq_out_lag", 32'(irq_out), 32'h0);
    tick();
    check("irq_out_set", 32'(irq_out), 32'h1);
    rd(0, "ints0", 9'h19C, 32'h0000_0001, 1'b0);
    rd(0, "intr", 9'h190, 32'h0000_0001, 1'b0);
    wr(0, 9'h198, 32'h0000_0001, 4'hF);
    intr_src = '0;
    check("irq_out_intf_a", 32'(irq_out), 32'h1);
    tick();
    check("irq_out_intf_b", 32'(irq_out), 32'h1);
    rd(0, "ints0_forced", 9'h19C, 32'h0000_0001, 1'b0);
    rd(0, "ints1_off", 9'h1A8, 32'h0000_0000, 1'b0);

    // Two-SM instance
    rd(1, "sm2_unmapped", 9'h0F8, 32'h0, 1'b1);
    wr(1, 9'h0F0, 32'h0000_E081, 4'hF);
    check("sm1_instr", 32'(sm_instr2[31:16]), 32'h0000_E081);
    check("sm1_instr_valid", 32'(sm_instr_valid2), 32'h2);
    tick();
    check("sm1_instr_valid_drop", 32'(sm_instr_valid2), 32'h0);

    // Reset during a pending read and a restart write
    bus.read_en = 1'b1; bus.read_addr = 9'h128;
    bus.write_en = 1'b1; bus.write_addr = 9'h000; bus.data_in = 32'h0000_0100;
    bus.write_strb = 4'hF;
    rst = 1'b1;
    tick();
    bus.read_en = 1'b0; bus.write_en = 1'b0;
    check("rst_mid_valid", 32'(bus.read_valid), 32'h0);
    check("rst_mid_err", 32'(bus.resp_err), 32'h0);
    check("rst_mid_restart", 32'(sm_restart), 32'h0);
    check("rst_mid_sm_en", 32'(sm_en), 32'h0);
    check("rst_mid_irq_out", 32'(irq_out), 32'h0);
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pio_csr_bank.md
# pio_csr_bank

Parametrised control/status register bank for the PIO block. It sits between the processor bus port and the NUM_SM state machines, FIFOs and IRQ logic. It holds all software-visible configuration, sticky W1C debug and IRQ flags, self-clearing command pulses, and the two interrupt output lines. It is the successor of the fixed four-SM register file, adding:

- a generic SM count
- byte-lane write strobes
- a registered read port with a valid/error response
- a computed interrupt path

## Interface
Parameters:
- NUM_SM, 4: number of state machines, legal 1..8.
- IMEM_SIZE, 32: instruction memory depth; reported in DBG_CFGINFO.
- FIFO_DEPTH, 4: FIFO depth; reported in DBG_CFGINFO.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- write_en  in  1  write request for the current cycle.
- write_addr  in  9  byte address of the write; word aligned.
- write_strb  in  4  byte-lane enables; bit k enables data_in[8k+7:8k].
- data_in  in  32  write data.
- read_en  in  1  read request for the current cycle.
- read_addr  in  9  byte address of the read; word aligned.
- data_out  out  32  read data; valid when read_valid=1, otherwise 0.
- read_valid  out  1  pulses 1 cycle after read_en.
- resp_err  out  1  pulses with read_valid, or 1 cycle after write_en, when the access hit an unmapped address.
- sm_en  out  NUM_SM  CTRL enable bits.
- sm_restart  out  NUM_SM  one-cycle restart pulses.
- clkdiv_restart  out  NUM_SM  one-cycle clock-divider restart pulses.
- fifo_stat  in  4*NUM_SM  {tx_empty, tx_full, rx_empty, rx_full}, NUM_SM bits per field.
- fifo_level  in  8*NUM_SM  per SM: {rx_level[3:0], tx_level[3:0]}.
- fdebug_set  in  4*NUM_SM  {tx_stall, tx_over, rx_under, rx_stall} event pulses.
- irq_set  in  8  hardware set of the IRQ flags.
- irq_clr  in  8  hardware clear of the IRQ flags.
- sync_bypass  out  32  INPUT_SYNC_BYPASS register contents.
- dbg_padout  in  32  pad output debug value, read-only.
- dbg_padoe  in  32  pad output-enable debug value, read-only.
- sm_clkdiv  out  24*NUM_SM  CLKDIV[31:8] per SM.
- sm_execctrl  out  32*NUM_SM  EXECCTRL per SM.
- sm_shiftctrl  out  16*NUM_SM  SHIFTCTRL[31:16] per SM.
- sm_pinctrl  out  32*NUM_SM  PINCTRL per SM.
- sm_addr  in  5*NUM_SM  current program counter per SM.
- sm_instr_cur  in  16*NUM_SM  current instruction per SM.
- sm_instr  out  16*NUM_SM  last instruction written via SMn_INSTR.
- sm_instr_valid  out  NUM_SM  one-cycle pulse after an SMn_INSTR write.
- intr_src  in  3*NUM_SM  {sm_irq, txnfull, rxnempty} raw interrupt sources.
- irq_out  out  2  IRQ0/IRQ1 request lines.

## Operation
Register map. Field n means bit n of the byte-aligned field; bits above NUM_SM read 0.
- 0x000 CTRL:
  - [7:0] SM_EN, RW.
  - [15:8] SM_RESTART, self-clearing (SC); reads 0.
  - [23:16] CLKDIV_RESTART, SC; reads 0.
- 0x004 FSTAT, RO. Bytes 0..3 are rx_full, rx_empty, tx_full, tx_empty.
- 0x008 FDEBUG, W1C sticky. Bytes 0..3 are rx_stall, rx_under, tx_over, tx_stall.
- 0x00C FLEVEL, RO. SMs 0..3 only, packed as in fifo_level.
- 0x030 IRQ[7:0], W1C.
- 0x038 INPUT_SYNC_BYPASS, RW.
- 0x03C DBG_PADOUT, RO.
- 0x040 DBG_PADOE, RO.
- 0x044 DBG_CFGINFO, RO: {IMEM_SIZE[21:16], NUM_SM[11:8], FIFO_DEPTH[5:0]}.
- SM n block, base 0x0C8 + 0x18·n:
  - +0x00 CLKDIV[31:8], RW.
  - +0x04 EXECCTRL: bit 31 and bits [6:5] are RO and read 0; the rest are RW.
  - +0x08 SHIFTCTRL[31:16], RW.
  - +0x0C ADDR, RO.
  - +0x10 INSTR: read returns sm_instr_cur; write latches sm_instr.
  - +0x14 PINCTRL, RW.
- 0x190 INTR, RO: bytes 0,1,2 are rxnempty, txnfull, sm_irq.
- IRQ0 at 0x194 / 0x198 / 0x19C: INTE (RW), INTF (RW), INTS (RO), same byte layout as INTR.
- IRQ1 at 0x1A0 / 0x1A4 / 0x1A8: INTE, INTF, INTS, same layout.
- Unmapped addresses, including SM blocks with n ≥ NUM_SM: reads return 0 with resp_err=1; writes are ignored with resp_err=1.

Write rules:
- Only bytes with a set write_strb bit affect the register. This applies to RW, W1C and SC fields alike.
- Writes to RO registers and RO fields are silently ignored, with no error.
- W1C next value = (cur | hw_set) & ~(sw_clr & ~hw_set). A hardware set in the same cycle as a software clear wins.
- IRQ additionally: irq_clr is applied after the software clear, and irq_set has priority over irq_clr.
- SC fields: a written 1 produces a one-cycle pulse on the next cycle, then the field returns to 0.
- INTS = (INTR | INTF) & INTE, computed combinationally from registered state and inputs.
- irq_out[k] = registered OR of IRQk INTS.

Reset values:
- clkdiv 0x00010000
- execctrl 0x0001F000
- shiftctrl 0x000C0000
- pinctrl 0x14000000
- all other storage 0
- all outputs 0, including read_valid, resp_err, all pulses and irq_out.

## Timing
- Writes take effect at the rising edge where write_en=1; new values appear on outputs the same edge.
- Reads: read_en at cycle t gives data_out/read_valid at t+1.
  - A read and a write to the same address in the same cycle return the pre-write value.
- sm_restart, clkdiv_restart and sm_instr_valid are high exactly in the cycle after the accepting write edge. Back-to-back writes produce back-to-back pulses.
- irq_out lags an INTS change by 1 cycle.
- rst asserted mid-transaction discards any pending read_valid/resp_err on the next edge. All pulses drop the same edge.

## Test plan
- Reset, then read 0x0C8, 0x0CC, 0x0D0, 0x0DC -> 0x00010000, 0x0001F000, 0x000C0000, 0x14000000, each with read_valid 1 cycle later.
- Write 0x0DC = 0xAABBCCDD with strb=0b0101 -> reads back 0x14BB00DD.
- Write CTRL = 0x00030205 -> sm_en=0x5 persistent; sm_restart=0x2 and clkdiv_restart=0x3 pulse for exactly one cycle; CTRL then reads 0x00000005.
- Pulse fdebug_set rx_stall[1]; FDEBUG reads 0x2. Write 0x2 to 0x008 in the same cycle as a new rx_stall[1] -> bit stays 1. Write 0x2 with no event -> reads 0.
- NUM_SM=2:
  - read 0x0F8 (SM2 CLKDIV) -> data 0, resp_err=1.
  - write SM1 INSTR 0xE081 -> sm_instr[1]=0xE081, sm_instr_valid=0b10 for one cycle.
- Set IRQ0 INTE=0x000001, drive rxnempty[0]=1 -> INTS=0x1, irq_out[0]=1 one cycle later. Drop the source and write INTF=0x1 -> irq_out[0] stays 1.
